mosfet_seq_calc: RTL and testbench
==================================

# mosfet_seq_calc

Sequential MOSFET calculator: the responder side of the lab's transistor-stimulus interface. It accepts six transistors serially over a valid handshake, computes each device's drain current (ID) or transconductance (gm), and insertion-sorts the values as they arrive. It then returns one weighted average on `out_n` with a one-cycle `out_valid` pulse. It sits between the stimulus/checker and the result-compare logic.

## Interface
- No parameters; all widths are fixed.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  high for exactly 6 consecutive cycles per frame, one transistor per cycle.
- `mode`  in  2  sampled only in the first `in_valid` cycle of a frame.
  - bit0: 1 = ID, 0 = gm.
  - bit1: 1 = largest three, 0 = smallest three.
- `W`  in  3  channel width, legal values 1..7.
- `V_GS`  in  3  gate-source voltage, legal values 1..7.
- `V_DS`  in  3  drain-source voltage, legal values 1..7.
- `out_valid`  out  1  one-cycle result strobe.
- `out_n`  out  10  result; must be 0 whenever `out_valid`=0.

## Operation
- Region per transistor:
  - triode when V_GS−1 > V_DS, otherwise saturation.
  - The compare is unsigned with no wrap; V_GS=1 is saturation with zero output.
- Triode:
  - ID = W·V_DS·(2·V_GS−2−V_DS)/3
  - gm = 2·W·V_DS/3
- Saturation:
  - ID = W·(V_GS−1)²/3
  - gm = 2·W·(V_GS−1)/3
- All divisions are integer truncation. Ranges: ID ≤ 84 (7 bits), gm ≤ 28 (5 bits). Only the metric selected by the latched `mode[0]` is computed and stored.
- Sorting:
  - Six-entry register file s0..s5, kept in descending order.
  - Each accepted sample is inserted in the same cycle it arrives (compare-and-shift).
  - Ties may be placed in either order; the result is unaffected.
- Result, where (a,b,c) = (s0,s1,s2) if `mode[1]`=1, else (s3,s4,s5):
  - ID mode: (3a + 4b + 5c)/12. Intermediate is ≥10 bits; max 1008.
  - gm mode: (a + b + c)/3.
- FSM:
  - IDLE: on `in_valid`, latch `mode`, insert sample 0, set cnt=1, go to LOAD.
  - LOAD: on `in_valid`, insert the sample and increment cnt. When the 6th sample (cnt=5) is inserted, go to CALC. If `in_valid`=0 mid-frame: protocol violation — discard the frame, clear the sort file, go to IDLE, emit no output.
  - CALC: compute the result and register it into `out_n`/`out_valid`; go to OUT.
  - OUT: `out_valid`=1 for this cycle only; go to IDLE.
- `in_valid` is ignored in CALC and OUT.
- Reset outputs: `out_valid`=0, `out_n`=0. Reset also sets state=IDLE, cnt=0 and clears the sort file.
- Reset mid-frame or mid-output aborts immediately. No `out_valid` follows for the aborted frame.

## Timing
- Frame samples arrive in cycles c0..c5 (`in_valid`=1). Each sample is captured at the rising edge ending its cycle.
- c6: CALC (combinational result). The result is registered at the edge ending c6.
- c7: `out_valid`=1 with `out_n` valid. Latency is 2 cycles after the last `in_valid` cycle.
- c8: `out_valid`=0, `out_n`=0. The earliest next frame starts its first `in_valid` cycle in c8; back-to-back frames therefore have a period of 8 cycles.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- All six transistors W=7, V_GS=7, V_DS=7 (saturation, ID=84 each), mode=3 → `out_n`=84 in c7; `out_valid` high for exactly 1 cycle.
- Six transistors sent in order as (W,V_GS,V_DS): (3,4,7), (3,2,7), (6,7,1), (7,7,7), (3,7,7), (6,3,7).
  - mode=0 → 4; mode=2 → 16 (gm sorted 28,12,8,6,4,2).
  - mode=1 → 5; mode=3 → 42 (ID sorted 84,36,22,9,8,1).
- The same six transistors in reversed input order, all four modes → identical results, proving order independence.
- `in_valid` dropped after 3 samples, then a full valid frame → no `out_valid` for the broken frame; the second frame gives the correct result at its c7.
- `rst` asserted in c4 of a frame, then a new frame → `out_valid`/`out_n` stay 0 until the new frame's c7.
- Back-to-back frames starting every 8 cycles with random legal inputs (1..7), compared against a golden model → all match; `out_n`=0 on every cycle where `out_valid`=0.

Source files
------------

// File: rtl/mosfet_seq_calc.sv
// Serial MOSFET calculator: takes six transistors per frame, computes ID or gm for each,
// keeps them insertion-sorted and returns a weighted average of the top or bottom three.
module mosfet_seq_calc (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [1:0] mode,
   input  logic [2:0] W,
   input  logic [2:0] V_GS,
   input  logic [2:0] V_DS,
   output logic       out_valid,
   output logic [9:0] out_n
);

   // state  | meaning
   // S_IDLE | waiting for the first sample of a frame
   // S_LOAD | receiving samples 2..6, aborts if in_valid drops
   // S_CALC | sort file complete, result registered this cycle
   // S_OUT  | out_valid strobe cycle
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_CALC = 2'd2;
   localparam logic [1:0] S_OUT  = 2'd3;

   logic [1:0] state;
   logic [2:0] cnt;
   logic [1:0] mode_r;
   logic [6:0] s    [6];
   logic [6:0] base [6];
   logic [6:0] ins  [6];

   logic [2:0] vov;
   logic       triode;
   logic [2:0] eff;
   logic [3:0] fac;
   logic [9:0] prod_id;
   logic [9:0] prod_gm;
   logic       sel_id;
   logic [6:0] sample;
   logic [6:0] a, b, c;
   logic [9:0] res;

   // ID = W*eff*fac/3 covers both regions: triode uses (V_DS, 2*vov-V_DS), saturation (vov, vov)
   assign vov     = (V_GS == 3'd0) ? 3'd0 : V_GS - 3'd1;
   assign triode  = vov > V_DS;
   assign eff     = triode ? V_DS : vov;
   assign fac     = triode ? ({vov, 1'b0} - {1'b0, V_DS}) : {1'b0, vov};
   assign prod_id = 10'(W) * 10'(eff) * 10'(fac);
   assign prod_gm = 10'(W) * 10'(eff) * 10'd2;
   assign sel_id  = (state == S_IDLE) ? mode[0] : mode_r[0];
   assign sample  = 7'((sel_id ? prod_id : prod_gm) / 10'd3);

   // The first sample of a frame always lands in an empty file
   always_comb begin
      for (int i = 0; i < 6; i++) begin
         base[i] = (state == S_IDLE) ? 7'd0 : s[i];
      end
      ins[0] = (base[0] >= sample) ? base[0] : sample;
      for (int i = 1; i < 6; i++) begin
         if (base[i] >= sample)
            ins[i] = base[i];
         else if (base[i-1] >= sample)
            ins[i] = sample;
         else
            ins[i] = base[i-1];
      end
   end

   always_comb begin
      a = mode_r[1] ? s[0] : s[3];
      b = mode_r[1] ? s[1] : s[4];
      c = mode_r[1] ? s[2] : s[5];
      if (mode_r[0])
         res = (10'd3 * 10'(a) + 10'd4 * 10'(b) + 10'd5 * 10'(c)) / 10'd12;
      else
         res = (10'(a) + 10'(b) + 10'(c)) / 10'd3;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= 3'd0;
         mode_r    <= 2'd0;
         out_valid <= 1'b0;
         out_n     <= 10'd0;
         for (int i = 0; i < 6; i++) s[i] <= 7'd0;
      end else begin
         out_valid <= 1'b0;
         out_n     <= 10'd0;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  mode_r <= mode;
                  s      <= ins;
                  cnt    <= 3'd1;
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (in_valid) begin
                  s <= ins;
                  if (cnt == 3'd5) begin
                     cnt   <= 3'd0;
                     state <= S_CALC;
                  end else begin
                     cnt <= cnt + 3'd1;
                  end
               end else begin
                  cnt   <= 3'd0;
                  state <= S_IDLE;
                  for (int i = 0; i < 6; i++) s[i] <= 7'd0;
               end
            end
            S_CALC: begin
               out_n     <= res;
               out_valid <= 1'b1;
               state     <= S_OUT;
            end
            default: begin
               state <= S_IDLE;
               for (int i = 0; i < 6; i++) s[i] <= 7'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mosfet_seq_calc.sv
// Scoreboard bench for mosfet_seq_calc: stimulus pushes expected results with their
// expected output cycle, a monitor pops and compares on every out_valid.
module tb_mosfet_seq_calc;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [2:0] W = 3'd0;
   logic [2:0] V_GS = 3'd0;
   logic [2:0] V_DS = 3'd0;
   logic       out_valid;
   logic [9:0] out_n;

   mosfet_seq_calc dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode),
      .W(W), .V_GS(V_GS), .V_DS(V_DS),
      .out_valid(out_valid), .out_n(out_n)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int val;
      int at;
   } exp_t;
   exp_t sb[$];
   exp_t e;

   int  checks = 0;
   int  errors = 0;
   bit  mon_en = 1'b0;

   function automatic int metric(int w, int vg, int vd, bit id);
      int ov;
      ov = vg - 1;
      if (ov > vd)
         return id ? (w * vd * (2 * ov - vd)) / 3 : (2 * w * vd) / 3;
      else
         return id ? (w * ov * ov) / 3 : (2 * w * ov) / 3;
   endfunction

   function automatic int golden(int md, int ws[6], int vgs[6], int vds[6]);
      int q[$];
      int a, b, c, k;
      for (int i = 0; i < 6; i++) q.push_back(metric(ws[i], vgs[i], vds[i], md[0]));
      q.rsort();
      k = md[1] ? 0 : 3;
      a = q[k]; b = q[k+1]; c = q[k+2];
      return md[0] ? (3 * a + 4 * b + 5 * c) / 12 : (a + b + c) / 3;
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         while (sb.size() > 0 && sb[0].at < cyc) begin
            e = sb.pop_front();
            checks++; errors++;
            $display("FAIL missing_result expected %0d at cycle %0d, result absent", e.val, e.at);
         end
         if (out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid out_n=%0d cycle=%0d", out_n, cyc);
            end else begin
               e = sb.pop_front();
               if (out_n !== 10'(e.val) || cyc != e.at) begin
                  errors++;
                  $display("FAIL result got %0d at cycle %0d, expected %0d at cycle %0d",
                           out_n, cyc, e.val, e.at);
               end
            end
         end else begin
            checks++;
            if (out_valid !== 1'b0 || out_n !== 10'd0) begin
               errors++;
               $display("FAIL idle_outputs out_valid=%b out_n=%0d expected 0/0 cycle=%0d",
                        out_valid, out_n, cyc);
            end
         end
      end
   end

   task automatic idle(int n);
      repeat (n) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         mode = 2'($urandom_range(0, 3));
         W    = 3'($urandom_range(0, 7));
         V_GS = 3'($urandom_range(0, 7));
         V_DS = 3'($urandom_range(0, 7));
      end
   endtask

   task automatic drive(int md, int w, int vg, int vd, bit first);
      @(posedge clk); #1;
      in_valid = 1'b1;
      mode = first ? 2'(md) : 2'($urandom_range(0, 3));
      W = 3'(w); V_GS = 3'(vg); V_DS = 3'(vd);
   endtask

   // Sends n samples; a full frame pushes its expected result (want < 0 uses the model)
   task automatic frame(int md, int ws[6], int vgs[6], int vds[6], int n, int want);
      int start;
      exp_t x;
      for (int i = 0; i < n; i++) begin
         drive(md, ws[i], vgs[i], vds[i], i == 0);
         if (i == 0) start = cyc;
      end
      idle(1);
      if (n == 6) begin
         x.val = (want >= 0) ? want : golden(md, ws, vgs, vds);
         x.at  = start + 7;
         sb.push_back(x);
      end
   endtask

   int ws[6], vgs[6], vds[6];
   int rws[6], rvgs[6], rvds[6];
   int all7[6];
   int want_fwd[4];

   initial begin
      all7 = '{7, 7, 7, 7, 7, 7};
      ws   = '{3, 3, 6, 7, 3, 6};
      vgs  = '{4, 2, 7, 7, 7, 3};
      vds  = '{7, 7, 1, 7, 7, 7};
      want_fwd = '{4, 5, 16, 42};
      for (int i = 0; i < 6; i++) begin
         rws[i] = ws[5-i]; rvgs[i] = vgs[5-i]; rvds[i] = vds[5-i];
      end

      @(posedge clk); #1;
      mon_en = 1'b1;
      idle(2);
      @(posedge clk); #1;
      rst = 1'b0;
      idle(2);

      frame(3, all7, all7, all7, 6, 84);
      idle(1);
      for (int m = 0; m < 4; m++) begin
         frame(m, ws, vgs, vds, 6, want_fwd[m]);
         idle(1);
      end
      for (int m = 0; m < 4; m++) begin
         frame(m, rws, rvgs, rvds, 6, want_fwd[m]);
         idle(1);
      end

      frame(3, ws, vgs, vds, 3, -1);
      idle(2);
      frame(1, ws, vgs, vds, 6, 5);
      idle(1);

      for (int i = 0; i < 4; i++) drive(3, ws[i], vgs[i], vds[i], i == 0);
      @(posedge clk); #1;
      rst = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      idle(1);
      frame(2, ws, vgs, vds, 6, 16);
      idle(1);

      for (int f = 0; f < 30; f++) begin
         int w6[6], g6[6], d6[6];
         for (int i = 0; i < 6; i++) begin
            w6[i] = $urandom_range(1, 7);
            g6[i] = $urandom_range(1, 7);
            d6[i] = $urandom_range(1, 7);
         end
         frame($urandom_range(0, 3), w6, g6, d6, 6, -1);
         idle(1);
      end

      idle(12);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
